// File: rtl/coin_acceptor_if.sv
// Coin-acceptor bundle: coin/price/cancel/ack from the front panel and dispenser,
// credit/vend/reject/change status back; master drives the inputs, slave is the acceptor.
interface coin_acceptor_if #(
   parameter int PRICE_W = 9
);
   logic               coin_valid;
   logic [1:0]         coin_type;
   logic [PRICE_W-1:0] price;
   logic               cancel;
   logic               change_ack;
   logic [PRICE_W-1:0] credit;
   logic               coin_reject;
   logic               vend;
   logic [PRICE_W-1:0] change;
   logic               change_valid;
   logic               busy;

   modport master (
      output coin_valid, coin_type, price, cancel, change_ack,
      input  credit, coin_reject, vend, change, change_valid, busy
   );

   modport slave (
      input  coin_valid, coin_type, price, cancel, change_ack,
      output credit, coin_reject, vend, change, change_valid, busy
   );
endinterface

// File: rtl/coin_acceptor.sv
// Accumulates coin credit against a latched price; vends with change or refunds on cancel.
// All outputs registered (1-cycle response); change held in PAYOUT until change_ack.
module coin_acceptor #(
   parameter int MAX_CREDIT = 399,
   parameter int PRICE_W    = 9
) (
   input  logic            clk,
   input  logic            reset,
   coin_acceptor_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, COLLECT, PAYOUT} state_t;

   localparam logic [PRICE_W:0] MAX_W = (PRICE_W+1)'(MAX_CREDIT);

   state_t             state, state_nxt;
   logic [PRICE_W-1:0] credit_q, credit_nxt;
   logic [PRICE_W-1:0] price_q, price_nxt;
   logic [PRICE_W-1:0] change_q, change_nxt;
   logic               vend_q, vend_nxt;
   logic               reject_q, reject_nxt;
   logic               cvalid_q, busy_q;

   logic [PRICE_W-1:0] coin_val;
   logic [PRICE_W-1:0] eff_price;
   logic [PRICE_W:0]   new_credit;
   logic               coin_fits;
   logic               paid;

   always_comb begin
      coin_val = '0;
      unique case (bus.coin_type)
         2'b00: coin_val = PRICE_W'(1);
         2'b01: coin_val = PRICE_W'(5);
         2'b10: coin_val = PRICE_W'(10);
         2'b11: coin_val = PRICE_W'(25);
      endcase
   end

   // credit is zero in IDLE, so the same sum serves the first coin of a transaction
   assign eff_price  = (state == IDLE) ? bus.price : price_q;
   assign new_credit = {1'b0, credit_q} + {1'b0, coin_val};
   assign coin_fits  = (new_credit <= MAX_W);
   assign paid       = (new_credit >= {1'b0, eff_price});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         credit_q <= '0;
         price_q  <= '0;
         change_q <= '0;
         vend_q   <= 1'b0;
         reject_q <= 1'b0;
         cvalid_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         credit_q <= credit_nxt;
         price_q  <= price_nxt;
         change_q <= change_nxt;
         vend_q   <= vend_nxt;
         reject_q <= reject_nxt;
         cvalid_q <= (state_nxt == PAYOUT);
         busy_q   <= (state_nxt != IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.coin_valid && coin_fits) state_nxt = paid ? PAYOUT : COLLECT;
         COLLECT: if (bus.cancel || (bus.coin_valid && coin_fits && paid)) state_nxt = PAYOUT;
         PAYOUT:  if (bus.change_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      credit_nxt = credit_q;
      price_nxt  = price_q;
      change_nxt = change_q;
      vend_nxt   = 1'b0;
      reject_nxt = 1'b0;
      unique case (state)
         IDLE, COLLECT: begin
            if (state == COLLECT && bus.cancel) begin
               change_nxt = credit_q;
               reject_nxt = bus.coin_valid;
            end else if (bus.coin_valid) begin
               if (coin_fits) begin
                  credit_nxt = new_credit[PRICE_W-1:0];
                  if (state == IDLE) price_nxt = bus.price;
                  if (paid) begin
                     vend_nxt   = 1'b1;
                     change_nxt = new_credit[PRICE_W-1:0] - eff_price;
                  end
               end else begin
                  reject_nxt = 1'b1;
               end
            end
         end
         PAYOUT: begin
            reject_nxt = bus.coin_valid;
            if (bus.change_ack) begin
               credit_nxt = '0;
               change_nxt = '0;
            end
         end
         default: ;
      endcase
   end

   assign bus.credit       = credit_q;
   assign bus.coin_reject  = reject_q;
   assign bus.vend         = vend_q;
   assign bus.change       = change_q;
   assign bus.change_valid = cvalid_q;
   assign bus.busy         = busy_q;
endmodule
